// File: rtl/btb_pkg.sv
// Shared types, counter encodings and index/tag helpers for the branch target buffer.
// Tags are stored at their configured width; the entry struct carries the widest supported tag.
package btb_pkg;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam int BTB_TAG_MAX = 30;

  typedef struct packed {
    logic                   valid;
    logic [BTB_TAG_MAX-1:0] tag;
    logic [31:0]            target;
    logic [1:0]             cnt;
  } btb_entry_t;

  function automatic logic [31:0] btb_idx(input logic [31:0] pc, input int idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] btb_tag(input logic [31:0] pc, input int idx_w, input int tag_w);
    return (pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
  endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Lookup/update/statistics bundle between the fetch/decode pipeline and the BTB.
// master = pipeline side, slave = predictor.
interface btb_predictor_if #(parameter int STAT_W = 32);
  logic [31:0]       if_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic              upd_valid;
  logic              upd_stall;
  logic              upd_kill;
  logic [31:0]       upd_pc;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic              upd_mispredict;
  logic              flush;
  logic [STAT_W-1:0] stat_lookups;
  logic [STAT_W-1:0] stat_hits;
  logic [STAT_W-1:0] stat_mispred;

  modport master (
    output if_pc, upd_valid, upd_stall, upd_kill, upd_pc, upd_taken, upd_target,
           upd_mispredict, flush,
    input  pred_hit, pred_taken, pred_target, stat_lookups, stat_hits, stat_mispred
  );

  modport slave (
    input  if_pc, upd_valid, upd_stall, upd_kill, upd_pc, upd_taken, upd_target,
           upd_mispredict, flush,
    output pred_hit, pred_taken, pred_target, stat_lookups, stat_hits, stat_mispred
  );
endinterface

// File: rtl/btb_sat_ctr.sv
// 2-bit saturating direction counter next-state: count up on taken, down on not-taken.
module btb_sat_ctr
  import btb_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_nxt
);

  always_comb begin
    cnt_nxt = cnt;
    if (taken) begin
      if (cnt != CNT_ST) cnt_nxt = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) cnt_nxt = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Tagged direct-mapped BTB: combinational lookup from IF, edge-applied update from ID.
// Optional statistics counters are built when BTB_STATS_EN is defined.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int         ENTRIES  = 64,
  parameter int         TAG_W    = 10,
  parameter logic [1:0] CNT_INIT = 2'b11,
  parameter int         STAT_W   = 32
) (
  input  logic            clk,
  input  logic            rst,
  btb_predictor_if.slave  bus
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         cnt_q    [ENTRIES];

  logic [IDX_W-1:0]       lk_idx;
  logic [BTB_TAG_MAX-1:0] lk_tag;
  btb_entry_t             lk_ent;
  logic                   lk_hit;

  assign lk_idx = IDX_W'(btb_idx(bus.if_pc, IDX_W));
  assign lk_tag = BTB_TAG_MAX'(btb_tag(bus.if_pc, IDX_W, TAG_W));

  // Read view of the addressed entry; no bypass from a same-cycle update.
  always_comb begin
    lk_ent.valid  = valid_q[lk_idx];
    lk_ent.tag    = BTB_TAG_MAX'(tag_q[lk_idx]);
    lk_ent.target = target_q[lk_idx];
    lk_ent.cnt    = cnt_q[lk_idx];
  end

  assign lk_hit          = lk_ent.valid && (lk_ent.tag == lk_tag);
  assign bus.pred_hit    = lk_hit;
  assign bus.pred_taken  = lk_hit && lk_ent.cnt[1];
  assign bus.pred_target = (lk_hit && lk_ent.cnt[1]) ? lk_ent.target : bus.if_pc + 32'd4;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             do_upd;
  logic [1:0]       up_cnt_nxt;

  assign up_idx = IDX_W'(btb_idx(bus.upd_pc, IDX_W));
  assign up_tag = TAG_W'(btb_tag(bus.upd_pc, IDX_W, TAG_W));
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign do_upd = bus.upd_valid & ~bus.upd_stall & ~bus.upd_kill & ~bus.flush;

  btb_sat_ctr u_sat_ctr (
    .cnt     (cnt_q[up_idx]),
    .taken   (bus.upd_taken),
    .cnt_nxt (up_cnt_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_SNT;
      end
    end else if (bus.flush) begin
      valid_q <= '0;
    end else if (do_upd) begin
      if (up_hit) begin
        cnt_q[up_idx] <= up_cnt_nxt;
        if (bus.upd_taken) target_q[up_idx] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        // Miss or tag conflict: a taken outcome claims the slot.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= bus.upd_target;
        cnt_q[up_idx]    <= CNT_INIT;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [STAT_W-1:0] stat_lookups_q;
  logic [STAT_W-1:0] stat_hits_q;
  logic [STAT_W-1:0] stat_mispred_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups_q <= '0;
      stat_hits_q    <= '0;
      stat_mispred_q <= '0;
    end else begin
      if (~&stat_lookups_q) stat_lookups_q <= stat_lookups_q + STAT_W'(1);
      if (lk_hit && ~&stat_hits_q) stat_hits_q <= stat_hits_q + STAT_W'(1);
      if (do_upd && bus.upd_mispredict && ~&stat_mispred_q)
        stat_mispred_q <= stat_mispred_q + STAT_W'(1);
    end
  end

  assign bus.stat_lookups = stat_lookups_q;
  assign bus.stat_hits    = stat_hits_q;
  assign bus.stat_mispred = stat_mispred_q;
`else
  logic unused_mispredict;
  assign unused_mispredict = bus.upd_mispredict;
  assign bus.stat_lookups  = '0;
  assign bus.stat_hits     = '0;
  assign bus.stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor: directed scenarios then random traffic against an array-level model.
module tb_btb_predictor;
  import btb_pkg::*;

  localparam int ENTRIES = 64;
  localparam int TAG_W   = 10;
  localparam int STAT_W  = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  btb_predictor_if #(.STAT_W(STAT_W)) bus ();

  btb_predictor #(
    .ENTRIES  (ENTRIES),
    .TAG_W    (TAG_W),
    .CNT_INIT (2'b11),
    .STAT_W   (STAT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain per-slot arrays, counter kept as an integer 0..3.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_cnt   [ENTRIES];
  longint      m_lookups, m_hits, m_misp;

  function automatic int unsigned slot_of(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % (1 << TAG_W);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats();
`ifdef BTB_STATS_EN
    check("stat_lookups", 64'(bus.stat_lookups), 64'(m_lookups));
    check("stat_hits",    64'(bus.stat_hits),    64'(m_hits));
    check("stat_mispred", 64'(bus.stat_mispred), 64'(m_misp));
`else
    check("stat_lookups", 64'(bus.stat_lookups), 64'd0);
    check("stat_hits",    64'(bus.stat_hits),    64'd0);
    check("stat_mispred", 64'(bus.stat_mispred), 64'd0);
`endif
  endtask

  // One cycle: drive, compare lookup against the model before the edge, then advance the model.
  task automatic step(input logic [31:0] lpc, input bit uv, input bit us, input bit uk,
                      input logic [31:0] upc, input bit ut, input logic [31:0] utg,
                      input bit um, input bit fl);
    int unsigned i, t;
    bit          e_hit, e_taken, d;
    logic [31:0] e_tgt;
    bus.if_pc = lpc; bus.upd_valid = uv; bus.upd_stall = us; bus.upd_kill = uk;
    bus.upd_pc = upc; bus.upd_taken = ut; bus.upd_target = utg;
    bus.upd_mispredict = um; bus.flush = fl;
    @(negedge clk);
    i = slot_of(lpc);
    t = tag_of(lpc);
    e_hit   = m_valid[i] && (m_tag[i] == t);
    e_taken = e_hit && (m_cnt[i] >= 2);
    e_tgt   = e_taken ? m_tgt[i] : lpc + 32'd4;
    check("pred_hit",    64'(bus.pred_hit),    64'(e_hit));
    check("pred_taken",  64'(bus.pred_taken),  64'(e_taken));
    check("pred_target", 64'(bus.pred_target), 64'(e_tgt));
    check_stats();
    @(posedge clk);
    m_lookups++;
    if (e_hit) m_hits++;
    d = uv && !us && !uk && !fl;
    if (d && um) m_misp++;
    if (fl) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
    end else if (d) begin
      i = slot_of(upc);
      t = tag_of(upc);
      if (m_valid[i] && m_tag[i] == t) begin
        if (ut) begin
          m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
          m_tgt[i] = utg;
        end else begin
          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
      end else if (ut) begin
        m_valid[i] = 1'b1; m_tag[i] = t; m_tgt[i] = utg; m_cnt[i] = 3;
      end
    end
    #1;
  endtask

  task automatic idle_look(input logic [31:0] lpc);
    step(lpc, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  logic [31:0] rpc, upc_r;

  initial begin
    checks = 0; errors = 0;
    m_lookups = 0; m_hits = 0; m_misp = 0;
    for (int k = 0; k < ENTRIES; k++) begin
      m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_cnt[k] = 0;
    end
    bus.if_pc = 32'h100; bus.upd_valid = 0; bus.upd_stall = 0; bus.upd_kill = 0;
    bus.upd_pc = 0; bus.upd_taken = 0; bus.upd_target = 0; bus.upd_mispredict = 0;
    bus.flush = 0;
    rst = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_hit",    64'(bus.pred_hit),    64'd0);
    check("rst_taken",  64'(bus.pred_taken),  64'd0);
    check("rst_target", 64'(bus.pred_target), 64'h104);
    check_stats();
    @(posedge clk); #2;
    rst = 1'b0;

    // Cold lookup misses
    idle_look(32'h100);
    check("t1_target", 64'(bus.pred_target), 64'h104);

    // Allocate on taken, visible next cycle
    step(32'h100, 1, 0, 0, 32'h100, 1, 32'h200, 1, 0);
    idle_look(32'h100);
    check("t2_hit",    64'(bus.pred_hit),    64'd1);
    check("t2_target", 64'(bus.pred_target), 64'h200);

    // Counter walks down and saturates at strong-NT
    for (int n = 0; n < 4; n++) step(32'h100, 1, 0, 0, 32'h100, 0, 32'h0, 0, 0);
    idle_look(32'h100);
    check("t3_taken",  64'(bus.pred_taken),  64'd0);
    check("t3_target", 64'(bus.pred_target), 64'h104);

    // Stalled and killed updates are dropped
    step(32'h100, 1, 1, 0, 32'h100, 1, 32'h300, 1, 0);
    step(32'h100, 1, 0, 1, 32'h100, 1, 32'h300, 1, 0);
    idle_look(32'h100);
    check("t4_taken", 64'(bus.pred_taken), 64'd0);

    // Same-index tag conflict replaces the entry
    step(32'h140, 1, 0, 0, 32'h140, 1, 32'h500, 0, 0);
    step(32'h140, 1, 0, 0, 32'h240, 1, 32'h600, 0, 0);
    idle_look(32'h140);
    check("t5_hit", 64'(bus.pred_hit), 64'd0);
    idle_look(32'h240);
    check("t5_alias_target", 64'(bus.pred_target), 64'h600);

    // Flush beats a same-cycle update
    step(32'h240, 1, 0, 0, 32'h380, 1, 32'h700, 1, 1);
    idle_look(32'h240);
    check("t6_hit_old", 64'(bus.pred_hit), 64'd0);
    idle_look(32'h380);
    check("t6_hit_new", 64'(bus.pred_hit), 64'd0);

    // Random traffic over a few slots and aliasing tags
    for (int n = 0; n < 400; n++) begin
      rpc   = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      upc_r = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 9) == 0) rpc = $urandom & 32'hFFFF_FFFC;
      step(rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, upc_r, 1'($urandom), $urandom & 32'hFFFF_FFFC,
           1'($urandom), $urandom_range(0, 49) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
